// File: rtl/vram_pkg.sv
// ---------------------------------------------------------------------------
// vram_pkg
// Constants and types shared by the framebuffer scanout block.
// Contents:
//   - 640x480@60 raster timing defaults and derived H/V totals
//   - default source image geometry (280x192) and its frame size
//   - SCALE: 2 when VRAM_SCANOUT_DOUBLE_EN is defined (pixel doubling), else 1
//   - scan_state_e: scanout state machine encoding {IDLE, RUN}
//   - raster_flags_t: per-pixel flags carried down the output delay line
// ---------------------------------------------------------------------------
package vram_pkg;

    localparam int DATA_WIDTH_D = 8;
    localparam int ADDR_WIDTH_D = 16;

    localparam int H_ACTIVE_D = 640;
    localparam int H_FP_D     = 16;
    localparam int H_SYNC_D   = 96;
    localparam int H_BP_D     = 48;
    localparam int H_TOTAL_D  = H_ACTIVE_D + H_FP_D + H_SYNC_D + H_BP_D;

    localparam int V_ACTIVE_D = 480;
    localparam int V_FP_D     = 10;
    localparam int V_SYNC_D   = 2;
    localparam int V_BP_D     = 33;
    localparam int V_TOTAL_D  = V_ACTIVE_D + V_FP_D + V_SYNC_D + V_BP_D;

    localparam int IMG_W_D  = 280;
    localparam int IMG_H_D  = 192;
    localparam int IMG_X0_D = 40;
    localparam int IMG_Y0_D = 48;

    // Words per source frame; the last address read in a frame is one less.
    function automatic int frame_size(input int w, input int h);
        return w * h;
    endfunction

    localparam int FRAME_SIZE_D = frame_size(IMG_W_D, IMG_H_D);

`ifdef VRAM_SCANOUT_DOUBLE_EN
    localparam int SCALE = 2;
`else
    localparam int SCALE = 1;
`endif

    // Raster counter width; covers totals up to 2047.
    localparam int CNT_W = 11;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } scan_state_e;

    typedef struct packed {
        logic active;
        logic hsync_n;
        logic vsync_n;
        logic fstart;
        logic in_win;
    } raster_flags_t;

    // Flag values of a blanking/idle position; also the reset value.
    localparam raster_flags_t FLAGS_IDLE = '{active: 1'b0, hsync_n: 1'b1,
                                             vsync_n: 1'b1, fstart: 1'b0,
                                             in_win: 1'b0};

endpackage

// File: rtl/vga_timing.sv
// ---------------------------------------------------------------------------
// vga_timing
// Horizontal/vertical raster counters and the combinational raster flags for
// the current counter position. Counters are held at 0 while run_i is low and
// start counting from (0,0) on the first clock with run_i high.
// Ports:
//   clk, rst_n      pixel clock, asynchronous active-low reset
//   run_i           1 = counters running, 0 = counters held at 0
//   h_o, v_o        current counter position
//   active_o        position inside the active area (0 when not running)
//   hsync_n_o       horizontal sync, active low (1 when not running)
//   vsync_n_o       vertical sync, active low (1 when not running)
//   fstart_o        position (0,0) while running
//   wrap_o          last position of the frame while running
// ---------------------------------------------------------------------------
module vga_timing
    import vram_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_D,
    parameter int H_FP     = H_FP_D,
    parameter int H_SYNC   = H_SYNC_D,
    parameter int H_BP     = H_BP_D,
    parameter int V_ACTIVE = V_ACTIVE_D,
    parameter int V_FP     = V_FP_D,
    parameter int V_SYNC   = V_SYNC_D,
    parameter int V_BP     = V_BP_D
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run_i,
    output logic [CNT_W-1:0] h_o,
    output logic [CNT_W-1:0] v_o,
    output logic             active_o,
    output logic             hsync_n_o,
    output logic             vsync_n_o,
    output logic             fstart_o,
    output logic             wrap_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_SBEG_C = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SEND_C = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] H_LAST_C = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] V_SBEG_C = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SEND_C = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] V_LAST_C = CNT_W'(V_TOTAL - 1);

    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;
    logic             h_last;
    logic             v_last;

    assign h_last = (h_q == H_LAST_C);
    assign v_last = (v_q == V_LAST_C);

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (!run_i) begin
            h_d = '0;
            v_d = '0;
        end else if (h_last) begin
            h_d = '0;
            v_d = v_last ? '0 : v_q + CNT_W'(1);
        end else begin
            h_d = h_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign h_o       = h_q;
    assign v_o       = v_q;
    assign active_o  = run_i && (h_q < H_ACT_C) && (v_q < V_ACT_C);
    assign hsync_n_o = !(run_i && (h_q >= H_SBEG_C) && (h_q < H_SEND_C));
    assign vsync_n_o = !(run_i && (v_q >= V_SBEG_C) && (v_q < V_SEND_C));
    assign fstart_o  = run_i && (h_q == '0) && (v_q == '0);
    assign wrap_o    = run_i && h_last && v_last;

endmodule

// File: rtl/vram_scanout.sv
// ---------------------------------------------------------------------------
// vram_scanout
// Read-side master for the dual-ported framebuffer RAM. Generates raster
// timing, walks the RAM read port row-major across the image window, and
// drives pixel/de/sync to the video output. The RAM read is registered, so
// every output for counter position N is presented together at N+3:
//   N   counter position       N+1 vram_adr registered
//   N+2 vram_q from the RAM    N+3 pix/de/hsync/vsync/frame_start
// Build option: define VRAM_SCANOUT_DOUBLE_EN to show each source pixel as a
// 2x2 block (window 2*IMG_W x 2*IMG_H); otherwise the mapping is 1:1.
// Ports:
//   clk, rst_n    pixel clock (also the RAM read clock), async active-low reset
//   en            scanout enable; dropping it finishes the current frame
//   border        pixel value for active area outside the image window
//   vram_adr      framebuffer read address (0 while idle)
//   vram_q        framebuffer read data, valid one clk after vram_adr
//   pix           output pixel, 0 whenever de is 0
//   de            active-video enable
//   hsync, vsync  syncs, active low
//   frame_start   one-clk pulse with the first active pixel of each frame
//   dbg_state     scanout state machine state
// ---------------------------------------------------------------------------
module vram_scanout
    import vram_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_D,
    parameter int ADDR_WIDTH = ADDR_WIDTH_D,
    parameter int IMG_W      = IMG_W_D,
    parameter int IMG_H      = IMG_H_D,
    parameter int IMG_X0     = IMG_X0_D,
    parameter int IMG_Y0     = IMG_Y0_D,
    parameter int H_ACTIVE   = H_ACTIVE_D,
    parameter int H_FP       = H_FP_D,
    parameter int H_SYNC     = H_SYNC_D,
    parameter int H_BP       = H_BP_D,
    parameter int V_ACTIVE   = V_ACTIVE_D,
    parameter int V_FP       = V_FP_D,
    parameter int V_SYNC     = V_SYNC_D,
    parameter int V_BP       = V_BP_D
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] border,
    output logic [ADDR_WIDTH-1:0] vram_adr,
    input  logic [DATA_WIDTH-1:0] vram_q,
    output logic [DATA_WIDTH-1:0] pix,
    output logic                  de,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  frame_start,
    output scan_state_e           dbg_state
);

    // Window bounds in display coordinates (right/bottom exclusive).
    localparam logic [CNT_W-1:0] WIN_X0 = CNT_W'(IMG_X0);
    localparam logic [CNT_W-1:0] WIN_X1 = CNT_W'(IMG_X0 + SCALE * IMG_W);
    localparam logic [CNT_W-1:0] WIN_XL = CNT_W'(IMG_X0 + SCALE * IMG_W - 1);
    localparam logic [CNT_W-1:0] WIN_Y0 = CNT_W'(IMG_Y0);
    localparam logic [CNT_W-1:0] WIN_Y1 = CNT_W'(IMG_Y0 + SCALE * IMG_H);
    localparam logic [ADDR_WIDTH-1:0] LINE_STEP = ADDR_WIDTH'(IMG_W);

    // ---------------------------------------------------------------- FSM
    scan_state_e state_q, state_d;
    logic        run;
    logic        wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Leaving RUN is only allowed at the frame wrap, so a dropped en always
    // lets the frame in flight complete.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en)          state_d = RUN;
            RUN:     if (wrap && !en) state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    always_comb begin
        run = (state_q == RUN);
    end

    assign dbg_state = state_q;

    // ------------------------------------------------------------- raster
    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic             t_active, t_hsync_n, t_vsync_n, t_fstart;
    logic             in_win;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
    ) u_timing (
        .clk       (clk),
        .rst_n     (rst_n),
        .run_i     (run),
        .h_o       (h_cnt),
        .v_o       (v_cnt),
        .active_o  (t_active),
        .hsync_n_o (t_hsync_n),
        .vsync_n_o (t_vsync_n),
        .fstart_o  (t_fstart),
        .wrap_o    (wrap)
    );

    assign in_win = run && (h_cnt >= WIN_X0) && (h_cnt < WIN_X1) &&
                    (v_cnt >= WIN_Y0) && (v_cnt < WIN_Y1);

    // --------------------------------------------------------- addressing
    // Row-major walk without a multiplier: line_base steps by IMG_W once per
    // SCALE window lines, x_idx steps once per SCALE window clocks. The
    // *_sub bits count the repeats when pixel doubling is enabled.
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH-1:0] x_idx_q, x_idx_d;
    logic                  x_sub_q, x_sub_d;
    logic                  y_sub_q, y_sub_d;

    always_comb begin
        adr_d   = adr_q;
        base_d  = base_q;
        x_idx_d = x_idx_q;
        x_sub_d = x_sub_q;
        y_sub_d = y_sub_q;
        if (!run) begin
            adr_d   = '0;
            base_d  = '0;
            x_idx_d = '0;
            x_sub_d = 1'b0;
            y_sub_d = 1'b0;
        end else begin
            if (t_fstart) begin
                base_d  = '0;
                y_sub_d = 1'b0;
            end
            if (in_win) begin
                adr_d = base_q + x_idx_q;
                if (SCALE == 1 || x_sub_q) x_idx_d = x_idx_q + ADDR_WIDTH'(1);
                x_sub_d = (SCALE == 1) ? 1'b0 : ~x_sub_q;
                // Last window pixel of a display line.
                if (h_cnt == WIN_XL) begin
                    if (SCALE == 1 || y_sub_q) base_d = base_q + LINE_STEP;
                    y_sub_d = (SCALE == 1) ? 1'b0 : ~y_sub_q;
                end
            end else begin
                // Outside the window the address holds; the column restarts
                // at the next window line.
                x_idx_d = '0;
                x_sub_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adr_q   <= '0;
            base_q  <= '0;
            x_idx_q <= '0;
            x_sub_q <= 1'b0;
            y_sub_q <= 1'b0;
        end else begin
            adr_q   <= adr_d;
            base_q  <= base_d;
            x_idx_q <= x_idx_d;
            x_sub_q <= x_sub_d;
            y_sub_q <= y_sub_d;
        end
    end

    assign vram_adr = adr_q;

    // --------------------------------------------------------- delay line
    // Flags ride two stages alongside the address and RAM read, then meet
    // vram_q in the output register.
    raster_flags_t flags0;
    raster_flags_t d1_q, d2_q;

    always_comb begin
        flags0.active  = t_active;
        flags0.hsync_n = t_hsync_n;
        flags0.vsync_n = t_vsync_n;
        flags0.fstart  = t_fstart;
        flags0.in_win  = in_win;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d1_q <= FLAGS_IDLE;
            d2_q <= FLAGS_IDLE;
        end else begin
            d1_q <= flags0;
            d2_q <= d1_q;
        end
    end

    // ---------------------------------------------------------- pixel mux
    logic [DATA_WIDTH-1:0] pix_q, pix_d;
    logic                  de_q, hsync_q, vsync_q, fs_q;

    always_comb begin
        pix_d = '0;
        if (d2_q.in_win)      pix_d = vram_q;
        else if (d2_q.active) pix_d = border;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_q   <= '0;
            de_q    <= 1'b0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            fs_q    <= 1'b0;
        end else begin
            pix_q   <= pix_d;
            de_q    <= d2_q.active;
            hsync_q <= d2_q.hsync_n;
            vsync_q <= d2_q.vsync_n;
            fs_q    <= d2_q.fstart;
        end
    end

    assign pix         = pix_q;
    assign de          = de_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = fs_q;

endmodule
